// File: rtl/mmc_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmc_bus_pkg
// Purpose  : Packet layout and FSM encoding shared by the bus-request decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mmc_bus_pkg;

    // 54-bit tagged request packet: [53] valid, [52:33] addr, [32] we, [31:0] wdata
    localparam int PKT_W     = 54;
    localparam int VALID_BIT = 53;
    localparam int ADDR_LSB  = 33;
    localparam int WE_BIT    = 32;

    // Transaction FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

endpackage : mmc_bus_pkg
`default_nettype wire

// File: rtl/mmc_bus_req_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : mmc_bus_req_decoder_if
// Purpose  : Red Pitaya sys_* register bus. master = requester (decoder),
//            slave = register bank answering with ack/err/rdata.
// Revision : 1.0 - initial release
// ============================================================================
interface mmc_bus_req_decoder_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       sys_addr_o;
    logic [DATA_W-1:0] sys_wdata_o;
    logic              sys_wen_o;
    logic              sys_ren_o;
    logic [DATA_W-1:0] sys_rdata_i;
    logic              sys_err_i;
    logic              sys_ack_i;

    modport master (
        output sys_addr_o, sys_wdata_o, sys_wen_o, sys_ren_o,
        input  sys_rdata_i, sys_err_i, sys_ack_i
    );

    modport slave (
        input  sys_addr_o, sys_wdata_o, sys_wen_o, sys_ren_o,
        output sys_rdata_i, sys_err_i, sys_ack_i
    );
endinterface : mmc_bus_req_decoder_if
`default_nettype wire

// File: rtl/mmc_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mmc_req_fifo
// Purpose  : Synchronous request buffer with full/empty flags. Pointers carry
//            one wrap bit so full and empty are told apart without a counter.
// Revision : 1.0 - initial release
// ============================================================================
module mmc_req_fifo #(
    parameter int WIDTH = 53,
    parameter int DEPTH = 4
) (
    input  wire logic             clk_i,
    input  wire logic             rstn_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] din_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; a push and a pop may happen in the same cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty_o guards reads
    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule : mmc_req_fifo
`default_nettype wire

// File: rtl/mmc_bus_req_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mmc_bus_req_decoder
// Purpose  : Responder for tagged bus-request packets. Buffers packets, runs
//            each as a single sys_* read or write and returns one response
//            pulse per transaction, strictly in packet order.
// Options  : MMC_REQ_TIMEOUT_EN - abort a transaction after TIMEOUT cycles
//            without ack and report it as an error response.
// Revision : 1.0 - initial release
// ============================================================================
module mmc_bus_req_decoder
    import mmc_bus_pkg::*;
#(
    parameter int          ADDR_W     = 20,
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h4060_0000,
    parameter int          TIMEOUT    = 255
) (
    input  wire logic              clk_i,
    input  wire logic              rstn_i,
    input  wire logic [PKT_W-1:0]  req_i,
    input  wire logic              ovf_clr_i,
    output logic                   ovf_o,
    output logic                   busy_o,
    mmc_bus_req_decoder_if.master  sys,
    output logic                   resp_valid_o,
    output logic                   resp_we_o,
    output logic                   resp_err_o,
    output logic      [DATA_W-1:0] resp_data_o
);
    localparam int ENT_W = ADDR_W + 1 + DATA_W;

    state_t              state_q, state_d;
    logic                ovf_q, ovf_d;
    logic [ADDR_W-1:0]   hold_addr_q;
    logic                hold_we_q;
    logic [DATA_W-1:0]   hold_wdata_q;
    logic                resp_err_q;
    logic [DATA_W-1:0]   resp_data_q;

    logic                w_req_vld;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic [ENT_W-1:0]    w_fifo_din;
    logic [ENT_W-1:0]    w_fifo_dout;
    logic                w_in_xfer;
    logic                w_ack;
    logic                w_timeout;

    assign w_req_vld  = req_i[VALID_BIT];
    assign w_fifo_din = {req_i[ADDR_LSB +: ADDR_W], req_i[WE_BIT], req_i[DATA_W-1:0]};
    assign w_pop      = (state_q == ST_IDLE) && !w_fifo_empty;
    assign w_in_xfer  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign w_ack      = w_in_xfer && sys.sys_ack_i;

    // Full is judged at cycle start, so a same-cycle pop frees no slot
    mmc_req_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (w_req_vld),
        .din_i   (w_fifo_din),
        .pop_i   (w_pop),
        .dout_o  (w_fifo_dout),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

`ifdef MMC_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt_q;

    // Cycles spent since ISSUE; cleared whenever no transaction is on the bus
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)        to_cnt_q <= '0;
        else if (w_in_xfer) to_cnt_q <= to_cnt_q + 1'b1;
        else                to_cnt_q <= '0;
    end

    assign w_timeout = w_in_xfer && !sys.sys_ack_i && (to_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // A drop in the same cycle as a clear leaves the flag set
    assign ovf_d = (w_req_vld && w_fifo_full) ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);

    // State, overflow flag, hold register and captured response
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            ovf_q        <= 1'b0;
            hold_addr_q  <= '0;
            hold_we_q    <= 1'b0;
            hold_wdata_q <= '0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            if (w_pop) begin
                {hold_addr_q, hold_we_q, hold_wdata_q} <= w_fifo_dout;
            end
            if (w_ack) begin
                resp_err_q  <= sys.sys_err_i;
                resp_data_q <= hold_we_q ? '0 : sys.sys_rdata_i;
            end else if (w_timeout) begin
                resp_err_q  <= 1'b1;
                resp_data_q <= '0;
            end
        end
    end

    // Next-state: ack (or timeout) in ISSUE skips WAIT entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!w_fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE: state_d = (sys.sys_ack_i || w_timeout) ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (sys.sys_ack_i || w_timeout) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; everything reads 0 outside its window
    always_comb begin
        sys.sys_wen_o   = (state_q == ST_ISSUE) &&  hold_we_q;
        sys.sys_ren_o   = (state_q == ST_ISSUE) && !hold_we_q;
        sys.sys_addr_o  = w_in_xfer ? (BASE_ADDR | {{(32-ADDR_W){1'b0}}, hold_addr_q}) : 32'h0;
        sys.sys_wdata_o = w_in_xfer ? hold_wdata_q : '0;
        resp_valid_o    = (state_q == ST_RESP);
        resp_we_o       = (state_q == ST_RESP) && hold_we_q;
        resp_err_o      = (state_q == ST_RESP) && resp_err_q;
        resp_data_o     = (state_q == ST_RESP) ? resp_data_q : '0;
        ovf_o           = ovf_q;
        busy_o          = (state_q != ST_IDLE) || !w_fifo_empty;
    end

endmodule : mmc_bus_req_decoder
`default_nettype wire

// File: tb/tb_mmc_bus_req_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmc_bus_req_decoder
// Purpose  : Directed self-checking bench for mmc_bus_req_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmc_bus_req_decoder;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [53:0] req_i;
    logic        ovf_clr_i;
    logic        ovf_o, busy_o;
    logic        resp_valid_o, resp_we_o, resp_err_o;
    logic [31:0] resp_data_o;

    int n_checks = 0;
    int n_errors = 0;

    mmc_bus_req_decoder_if #(.DATA_W(32)) sys_if ();

    mmc_bus_req_decoder #(
        .ADDR_W     (20),
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (32'h4060_0000),
        .TIMEOUT    (8)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .ovf_clr_i    (ovf_clr_i),
        .ovf_o        (ovf_o),
        .busy_o       (busy_o),
        .sys          (sys_if),
        .resp_valid_o (resp_valid_o),
        .resp_we_o    (resp_we_o),
        .resp_err_o   (resp_err_o),
        .resp_data_o  (resp_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [53:0] pkt(input logic [19:0] a, input logic we, input logic [31:0] d);
        return {1'b1, a, we, d};
    endfunction

    // Step until a transaction is on the bus (address becomes non-zero)
    task automatic wait_bus(input string tag);
        for (int k = 0; k < 12 && sys_if.sys_addr_o == 32'h0; k++) step();
        chk(tag, {31'h0, sys_if.sys_addr_o != 32'h0}, 32'h1);
    endtask

    initial begin
        int strobes;
        int resps;
        logic [53:0] r;

        rstn_i = 1'b0;
        req_i = '0;
        ovf_clr_i = 1'b0;
        sys_if.sys_ack_i = 1'b0;
        sys_if.sys_err_i = 1'b0;
        sys_if.sys_rdata_i = 32'h0;
        step();
        step();
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_outs", {26'h0, ovf_o, resp_valid_o, resp_we_o, resp_err_o,
                         sys_if.sys_wen_o, sys_if.sys_ren_o}, 32'h0);
        chk("rst_addr", sys_if.sys_addr_o, 32'h0);
        rstn_i = 1'b1;
        step();

        // ---- write, ack 3 cycles after strobe ----
        req_i = pkt(20'h00010, 1'b1, 32'hDEADBEEF);
        step();                                   // cycle 1
        req_i = '0;
        chk("wr_busy", {31'h0, busy_o}, 32'h1);
        chk("wr_c1_nostrobe", {31'h0, sys_if.sys_wen_o}, 32'h0);
        step();                                   // cycle 2
        chk("wr_wen", {30'h0, sys_if.sys_wen_o, sys_if.sys_ren_o}, 32'h2);
        chk("wr_addr", sys_if.sys_addr_o, 32'h4060_0010);
        chk("wr_wdata", sys_if.sys_wdata_o, 32'hDEADBEEF);
        step();                                   // cycle 3
        chk("wr_wen_1cyc", {31'h0, sys_if.sys_wen_o}, 32'h0);
        chk("wr_addr_hold", sys_if.sys_addr_o, 32'h4060_0010);
        step();                                   // cycle 4
        step();                                   // cycle 5
        sys_if.sys_ack_i = 1'b1;
        sys_if.sys_rdata_i = 32'hFFFF_FFFF;
        chk("wr_no_early_resp", {31'h0, resp_valid_o}, 32'h0);
        step();                                   // cycle 6
        sys_if.sys_ack_i = 1'b0;
        chk("wr_resp", {29'h0, resp_valid_o, resp_we_o, resp_err_o}, 32'h6);
        chk("wr_resp_data", resp_data_o, 32'h0);
        step();
        chk("wr_resp_1cyc", {31'h0, resp_valid_o}, 32'h0);
        chk("wr_idle", {31'h0, busy_o}, 32'h0);

        // ---- read, ack in the ISSUE cycle ----
        req_i = pkt(20'h00020, 1'b0, 32'hA5A5A5A5);
        step();
        req_i = '0;
        step();
        chk("rd_ren", {30'h0, sys_if.sys_wen_o, sys_if.sys_ren_o}, 32'h1);
        chk("rd_addr", sys_if.sys_addr_o, 32'h4060_0020);
        sys_if.sys_ack_i = 1'b1;
        sys_if.sys_rdata_i = 32'h12345678;
        step();
        sys_if.sys_ack_i = 1'b0;
        sys_if.sys_rdata_i = 32'h0;
        chk("rd_resp", {29'h0, resp_valid_o, resp_we_o, resp_err_o}, 32'h4);
        chk("rd_data", resp_data_o, 32'h12345678);
        chk("rd_ren_off", {31'h0, sys_if.sys_ren_o}, 32'h0);
        step();
        chk("rd_resp_1cyc", {31'h0, resp_valid_o}, 32'h0);

        // ---- overflow: 6 packets, ack low; last one dropped with clear asserted ----
        for (int i = 0; i < 6; i++) begin
            req_i = pkt(20'h00100 + 20'(i), 1'b1, 32'(i));
            ovf_clr_i = (i == 5);
            if (i == 5) chk("ovf_before_drop", {31'h0, ovf_o}, 32'h0);
            step();
        end
        req_i = '0;
        chk("ovf_drop_wins", {31'h0, ovf_o}, 32'h1);
        step();
        ovf_clr_i = 1'b0;
        chk("ovf_clear", {31'h0, ovf_o}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            wait_bus("ovf_wait_bus");
            chk("ovf_order_addr", sys_if.sys_addr_o, 32'h4060_0100 + 32'(i));
            chk("ovf_order_wdata", sys_if.sys_wdata_o, 32'(i));
            sys_if.sys_ack_i = 1'b1;
            step();
            sys_if.sys_ack_i = 1'b0;
            chk("ovf_resp", {30'h0, resp_valid_o, resp_we_o}, 32'h3);
            step();
        end
        step();
        step();
        chk("ovf_dropped_gone", {31'h0, busy_o}, 32'h0);

        // ---- invalid packets and stray acks ----
        strobes = 0;
        resps = 0;
        for (int i = 0; i < 100; i++) begin
            r[31:0]  = $urandom;
            r[52:32] = 21'($urandom);
            r[53]    = 1'b0;
            req_i = r;
            sys_if.sys_ack_i = 1'($urandom_range(0, 1));
            step();
            if (sys_if.sys_wen_o || sys_if.sys_ren_o) strobes++;
            if (resp_valid_o || busy_o) resps++;
        end
        req_i = '0;
        sys_if.sys_ack_i = 1'b0;
        chk("inv_strobes", 32'(strobes), 32'h0);
        chk("inv_busy_resp", 32'(resps), 32'h0);

        // ---- reset while in WAIT ----
        req_i = pkt(20'h00030, 1'b0, 32'h0);
        step();
        req_i = '0;
        step();
        chk("rst_wait_ren", {31'h0, sys_if.sys_ren_o}, 32'h1);
        step();
        rstn_i = 1'b0;
        #1;
        chk("rstw_addr", sys_if.sys_addr_o, 32'h0);
        chk("rstw_outs", {29'h0, busy_o, resp_valid_o, ovf_o}, 32'h0);
        step();
        rstn_i = 1'b1;
        resps = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (resp_valid_o || busy_o) resps++;
        end
        chk("rstw_no_resp", 32'(resps), 32'h0);
        req_i = pkt(20'h00040, 1'b1, 32'hCAFE0001);
        step();
        req_i = '0;
        step();
        chk("rstw_next_wen", {31'h0, sys_if.sys_wen_o}, 32'h1);
        chk("rstw_next_addr", sys_if.sys_addr_o, 32'h4060_0040);
        sys_if.sys_ack_i = 1'b1;
        sys_if.sys_err_i = 1'b1;
        step();
        sys_if.sys_ack_i = 1'b0;
        sys_if.sys_err_i = 1'b0;
        chk("rstw_next_resp", {29'h0, resp_valid_o, resp_we_o, resp_err_o}, 32'h7);
        step();

`ifdef MMC_REQ_TIMEOUT_EN
        // ---- timeout: read with no ack ----
        req_i = pkt(20'h00050, 1'b0, 32'h0);
        step();
        req_i = '0;
        step();
        chk("to_ren", {31'h0, sys_if.sys_ren_o}, 32'h1);
        for (int i = 0; i < 7; i++) step();
        chk("to_not_yet", {31'h0, resp_valid_o}, 32'h0);
        step();
        chk("to_resp", {29'h0, resp_valid_o, resp_we_o, resp_err_o}, 32'h5);
        chk("to_data", resp_data_o, 32'h0);
        step();
        sys_if.sys_ack_i = 1'b1;
        sys_if.sys_rdata_i = 32'h0BAD_0BAD;
        step();
        sys_if.sys_ack_i = 1'b0;
        chk("to_late_ack", {30'h0, resp_valid_o, busy_o}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mmc_bus_req_decoder
`default_nettype wire
